// File: rtl/mem_responder.sv
// mem_responder: single-request load/store responder with a byte-lane RAM,
// an 8-bit LED register and a free-running millisecond counter. One request
// is in flight at a time. Fault-free requests respond WAIT_STATES cycles
// after an initial cycle; faulted requests respond on the next cycle.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CLK_PER_MS  = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [7:0]  led,
  output logic [31:0] ms_count
);

  localparam int unsigned     AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned     PW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [31:0]     RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0]     LED_ADDR  = 32'hFFFF_FFF0;
  localparam logic [31:0]     MS_ADDR   = 32'hFFFF_FFF4;
  localparam logic [3:0]      WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_t;

  state_t         state_q, state_d;
  logic           write_q, write_d;
  logic [31:0]    addr_q, addr_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           fault_q, fault_d;
  logic [3:0]     wait_cnt_q, wait_cnt_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_error_q, rsp_error_d;
  logic [7:0]     led_q, led_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [31:0]    ms_q, ms_d;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           enter_rsp;
  logic           mem_we;
  logic [3:0]     mem_be;
  logic [31:0]    mem_wdata;
  logic [AW-1:0]  word_idx;
  logic [31:0]    rd_word;
  logic [31:0]    rd_shift;
  logic [31:0]    load_data;

  // Width code, alignment and address-map checks for one request.
  function automatic logic access_fault(input logic [31:0] addr, input logic [2:0] f3,
                                        input logic wr);
    logic bad_width;
    logic misaligned;
    logic unmapped;
    if (wr) bad_width = !(f3 inside {3'b000, 3'b001, 3'b010});
    else    bad_width = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    unmapped   = !((addr < RAM_BYTES) || (addr == LED_ADDR) || (addr == MS_ADDR));
    return bad_width || misaligned || unmapped;
  endfunction

  // FSM next state and request capture in IDLE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          fault_d  = access_fault(req_addr, req_funct3, req_write);
          if (fault_d || (WAIT_STATES == 0)) begin
            state_d = ST_RESPOND;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_RESPOND;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The edge entering RESPOND is the access edge; the *_d request fields are
  // valid there whether we come from WAIT or straight from IDLE.
  assign enter_rsp = (state_d == ST_RESPOND) && !rst;

  // Load data formation and store byte-lane steering.
  always_comb begin
    word_idx  = addr_d[AW+1:2];
    rd_word   = mem[word_idx];
    rd_shift  = rd_word >> {addr_d[1:0], 3'b000};
    case (funct3_d)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b101:  load_data = {16'b0, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
    if (addr_d == LED_ADDR)     load_data = {24'b0, led_q};
    else if (addr_d == MS_ADDR) load_data = ms_q;
    case (funct3_d[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << addr_d[1:0];
        mem_wdata = {4{wdata_d[7:0]}};
      end
      2'b01: begin
        mem_be    = 4'b0011 << addr_d[1:0];
        mem_wdata = {2{wdata_d[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_d;
      end
    endcase
  end

  // Response capture, LED write and RAM write enable on the access edge.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    led_d       = led_q;
    mem_we      = 1'b0;
    if (enter_rsp) begin
      rsp_error_d = fault_d;
      rsp_rdata_d = (fault_d || write_d) ? 32'd0 : load_data;
      if (!fault_d && write_d) begin
        if (addr_d < RAM_BYTES) mem_we = 1'b1;
        if (addr_d == LED_ADDR) led_d  = wdata_d[7:0];
      end
    end
  end

  // Millisecond prescaler and counter.
  always_comb begin
    presc_d = presc_q + PW'(1);
    ms_d    = ms_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      ms_d    = ms_q + 32'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      led_q       <= '0;
      presc_q     <= '0;
      ms_q        <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      led_q       <= led_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
    end
  end

  // RAM byte-lane write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; its contents survive rst and it can
    // map onto block memory.
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESPOND);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign led       = led_q;
  assign ms_count  = ms_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 2048, sets the RAM size in 32-bit words (byte size 4*DEPTH_WORDS).
REQ-002 Parameter WAIT_STATES, default 1, sets the number of extra cycles between request acceptance and response (0..15).
REQ-003 Parameter CLK_PER_MS, default 12000, sets the number of clk cycles per millisecond tick.
REQ-004 Port clk, in, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, in, 1: reset, asynchronous and active-high.
REQ-006 Port req_valid, in, 1: the initiator presents a request.
REQ-007 Port req_write, in, 1: 1 = store, 0 = load.
REQ-008 Port req_addr, in, 32: byte address.
REQ-009 Port req_funct3, in, 3: RISC-V load/store funct3 width code.
REQ-010 Port req_wdata, in, 32: store data, right-aligned.
REQ-011 Port req_ready, out, 1: the responder accepts a request this cycle.
REQ-012 Port rsp_valid, out, 1: one-cycle pulse marking completion.
REQ-013 Port rsp_rdata, out, 32: load result, extended per funct3.
REQ-014 Port rsp_error, out, 1: the completed request faulted; valid while rsp_valid=1.
REQ-015 Port led, out, 8: LED register.
REQ-016 Port ms_count, out, 32: free-running millisecond counter.

Function
REQ-017 FSM states: IDLE, WAIT, RESPOND; req_ready=1 only in IDLE.
REQ-018 Acceptance: req_valid=1 at a rising edge in IDLE latches addr/funct3/wdata/write.
REQ-019 Latched fault: go to RESPOND directly. Latched no fault: go to WAIT if WAIT_STATES>0, otherwise to RESPOND.
REQ-020 WAIT holds for exactly WAIT_STATES cycles (down-counter), then goes to RESPOND.
REQ-021 RESPOND lasts one cycle with rsp_valid=1, then returns to IDLE.
REQ-022 Latency: rsp_valid is high in cycle N+1+WAIT_STATES for a fault-free request accepted at edge N, and in cycle N+1 for a faulted request.
REQ-023 req_valid outside IDLE is ignored; requests are not queued.
REQ-024 rsp_rdata and rsp_error hold their values until the next RESPOND.
REQ-025 Stores commit on the edge that enters RESPOND. Loads sample storage on that same edge.
REQ-026 funct3 decode:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - any other code is a fault.
REQ-027 Misalignment is a fault: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-028 Memory map:
  - 0x0000_0000 .. 4*DEPTH_WORDS-1: RAM
  - 0xFFFF_FFF0: LED register
  - 0xFFFF_FFF4: ms_count
  - any other address is a fault.
REQ-029 RAM stores write only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes); other lanes are unchanged.
REQ-030 RAM loads select lanes by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-031 LED register: a store of any width writes wdata[7:0] to led; a load returns {24'b0, led}.
REQ-032 ms_count is read-only: stores to it complete with no effect and no fault; loads return its current value.
REQ-033 Prescaler counts 0..CLK_PER_MS-1; ms_count increments when the prescaler wraps and wraps 0xFFFF_FFFF -> 0.
REQ-034 A faulted request changes no storage and returns rsp_rdata=0 with rsp_error=1.

Reset
REQ-035 rst=1 immediately forces state IDLE and sets to 0: rsp_valid, rsp_rdata, rsp_error, led, ms_count, prescaler, and wait counter.
REQ-036 RAM contents are not cleared by reset.
REQ-037 Reset in WAIT abandons the request with no store commit and no response.
REQ-038 req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-039 WAIT_STATES=1: SW 0x8 = 0xDEADBEEF, then LW 0x8 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after acceptance, rsp_error=0.
REQ-040 After REQ-039: SB 0x9 = 0xAA; then
  - LB 0x9 -> 0xFFFFFFAA
  - LBU 0x9 -> 0x000000AA
  - LW 0x8 -> 0xDEADAAEF.
REQ-041 LH 0x3 and LW 0x2000_0000 -> each gives rsp_error=1 and rsp_rdata=0 one cycle after acceptance; a following LW 0x0 returns unchanged data.
REQ-042 SW 0xFFFF_FFF0 = 0x123456A5 -> led=0xA5; LW 0xFFFF_FFF0 -> 0x000000A5.
REQ-043 CLK_PER_MS=4, 40 cycles after reset release -> ms_count=10; SW to 0xFFFF_FFF4 leaves it counting.
REQ-044 WAIT_STATES=3: rst pulses during WAIT of SW 0x0 = 0x11111111 -> no rsp_valid; a later LW 0x0 returns the prior value.
